// File: rtl/mouse_cursor_tracker.sv
// Hardware cursor engine: buffers relative HID mouse reports and integrates them into a
// clamped or wrapped absolute screen position with button levels and edge pulses.
module mouse_cursor_tracker #(
    parameter int unsigned COORD_W     = 16,
    parameter int unsigned DELTA_W     = 8,
    parameter int unsigned NUM_BUTTONS = 2,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SPEED_SHIFT = 0,
    parameter bit          WRAP_MODE   = 1'b0,
    parameter bit          FRAME_SYNC  = 1'b0
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   rpt_valid,
    output logic                   rpt_ready,
    input  logic [DELTA_W-1:0]     rpt_dx,
    input  logic [DELTA_W-1:0]     rpt_dy,
    input  logic [NUM_BUTTONS-1:0] rpt_buttons,
    input  logic                   set_valid,
    input  logic [COORD_W-1:0]     set_x,
    input  logic [COORD_W-1:0]     set_y,
    input  logic                   frame_start,
    output logic [COORD_W-1:0]     mousex_export,
    output logic [COORD_W-1:0]     mousey_export,
    output logic [NUM_BUTTONS-1:0] pbutton_export,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned AW      = COORD_W + 2;
    localparam int unsigned ENTRY_W = 2 * DELTA_W + NUM_BUTTONS;

    localparam logic signed [AW-1:0] SW_LIM  = AW'(SCREEN_W);
    localparam logic signed [AW-1:0] SW_MAX  = AW'(SCREEN_W - 1);
    localparam logic signed [AW-1:0] SH_LIM  = AW'(SCREEN_H);
    localparam logic signed [AW-1:0] SH_MAX  = AW'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0]   X_MAX   = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0]   Y_MAX   = COORD_W'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0]   X_RESET = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0]   Y_RESET = COORD_W'(SCREEN_H / 2);

    // Report FIFO
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] head;

    assign full      = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign rpt_ready = ~full;
    assign push      = rpt_valid & ~full;
    assign pop       = ~empty & ~set_valid;
    assign head      = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {rpt_buttons, rpt_dy, rpt_dx};
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

    // Integrate one axis; the scaled delta is assumed smaller than the screen span.
    function automatic logic [COORD_W-1:0] integrate(
        input logic [COORD_W-1:0] cur,
        input logic [DELTA_W-1:0] delta,
        input logic signed [AW-1:0] lim,
        input logic signed [AW-1:0] lim_max
    );
        logic signed [AW-1:0] dext;
        logic signed [AW-1:0] sum;
        dext = AW'($signed(delta));
        dext = dext <<< SPEED_SHIFT;
        sum  = $signed({2'b00, cur}) + dext;
        if (WRAP_MODE) begin
            if (sum[AW-1]) begin
                sum = sum + lim;
            end else if (sum >= lim) begin
                sum = sum - lim;
            end
        end else begin
            if (sum[AW-1]) begin
                sum = '0;
            end else if (sum > lim_max) begin
                sum = lim_max;
            end
        end
        return sum[COORD_W-1:0];
    endfunction

    // Cursor state
    logic [COORD_W-1:0]     cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [NUM_BUTTONS-1:0] cur_btn_q, cur_btn_d;
    logic [NUM_BUTTONS-1:0] press_q, press_d, release_q, release_d;
    logic [DELTA_W-1:0]     head_dx, head_dy;
    logic [NUM_BUTTONS-1:0] head_btn;

    assign head_dx  = head[DELTA_W-1:0];
    assign head_dy  = head[2*DELTA_W-1:DELTA_W];
    assign head_btn = head[ENTRY_W-1:2*DELTA_W];

    always_comb begin
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        cur_btn_d = cur_btn_q;
        press_d   = '0;
        release_d = '0;
        if (set_valid) begin
            cur_x_d = (set_x > X_MAX) ? X_MAX : set_x;
            cur_y_d = (set_y > Y_MAX) ? Y_MAX : set_y;
        end else if (pop) begin
            cur_x_d   = integrate(cur_x_q, head_dx, SW_LIM, SW_MAX);
            cur_y_d   = integrate(cur_y_q, head_dy, SH_LIM, SH_MAX);
            cur_btn_d = head_btn;
            press_d   = head_btn & ~cur_btn_q;
            release_d = ~head_btn & cur_btn_q;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cur_x_q   <= X_RESET;
            cur_y_q   <= Y_RESET;
            cur_btn_q <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            cur_btn_q <= cur_btn_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pbutton_export = cur_btn_q;
    assign press_pulse    = press_q;
    assign release_pulse  = release_q;

    if (FRAME_SYNC) begin : g_frame_sync
        logic [COORD_W-1:0] shadow_x_q, shadow_y_q;

        // Captures the pre-update position when a pop or set lands on the frame edge.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                shadow_x_q <= X_RESET;
                shadow_y_q <= Y_RESET;
            end else if (frame_start) begin
                shadow_x_q <= cur_x_q;
                shadow_y_q <= cur_y_q;
            end
        end

        assign mousex_export = shadow_x_q;
        assign mousey_export = shadow_y_q;
    end else begin : g_direct
        assign mousex_export = cur_x_q;
        assign mousey_export = cur_y_q;
    end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed bench for mouse_cursor_tracker: clamp, wrap and frame-synchronous instances
// share one stimulus stream and are checked against hand-computed values.
module tb_mouse_cursor_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rpt_valid;
    logic [7:0]  rpt_dx, rpt_dy;
    logic [1:0]  rpt_buttons;
    logic        set_valid;
    logic [15:0] set_x, set_y;
    logic        frame_start;

    logic        rdy0, rdy1, rdy2;
    logic [15:0] mx0, my0, mx1, my1, mx2, my2;
    logic [1:0]  pb0, pp0, rp0, pb1, pp1, rp1, pb2, pp2, rp2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mouse_cursor_tracker u_clamp (
        .clk_clk(clk), .reset_reset_n(rst_n), .rpt_valid(rpt_valid), .rpt_ready(rdy0),
        .rpt_dx(rpt_dx), .rpt_dy(rpt_dy), .rpt_buttons(rpt_buttons), .set_valid(set_valid),
        .set_x(set_x), .set_y(set_y), .frame_start(frame_start), .mousex_export(mx0),
        .mousey_export(my0), .pbutton_export(pb0), .press_pulse(pp0), .release_pulse(rp0)
    );

    mouse_cursor_tracker #(.WRAP_MODE(1'b1)) u_wrap (
        .clk_clk(clk), .reset_reset_n(rst_n), .rpt_valid(rpt_valid), .rpt_ready(rdy1),
        .rpt_dx(rpt_dx), .rpt_dy(rpt_dy), .rpt_buttons(rpt_buttons), .set_valid(set_valid),
        .set_x(set_x), .set_y(set_y), .frame_start(frame_start), .mousex_export(mx1),
        .mousey_export(my1), .pbutton_export(pb1), .press_pulse(pp1), .release_pulse(rp1)
    );

    mouse_cursor_tracker #(.FRAME_SYNC(1'b1)) u_fsync (
        .clk_clk(clk), .reset_reset_n(rst_n), .rpt_valid(rpt_valid), .rpt_ready(rdy2),
        .rpt_dx(rpt_dx), .rpt_dy(rpt_dy), .rpt_buttons(rpt_buttons), .set_valid(set_valid),
        .set_x(set_x), .set_y(set_y), .frame_start(frame_start), .mousex_export(mx2),
        .mousey_export(my2), .pbutton_export(pb2), .press_pulse(pp2), .release_pulse(rp2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        rpt_valid   = 1'b0;
        rpt_dx      = '0;
        rpt_dy      = '0;
        rpt_buttons = '0;
        set_valid   = 1'b0;
        set_x       = '0;
        set_y       = '0;
        frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [7:0] dx, input logic [7:0] dy, input logic [1:0] b);
        rpt_valid   = 1'b1;
        rpt_dx      = dx;
        rpt_dy      = dy;
        rpt_buttons = b;
        step();
        rpt_valid   = 1'b0;
    endtask

    task automatic load(input logic [15:0] x, input logic [15:0] y);
        set_valid = 1'b1;
        set_x     = x;
        set_y     = y;
        step();
        set_valid = 1'b0;
    endtask

    logic [1:0] btn_seq [4];
    logic [1:0] exp_press [4];
    logic [1:0] exp_rel [4];

    initial begin
        btn_seq   = '{2'b00, 2'b01, 2'b11, 2'b00};
        exp_press = '{2'b00, 2'b01, 2'b10, 2'b00};
        exp_rel   = '{2'b00, 2'b00, 2'b00, 2'b11};

        do_reset();
        check("reset_x", mx0, 320);
        check("reset_y", my0, 240);
        check("reset_btn", pb0, 0);
        check("reset_ready", rdy0, 1);
        check("reset_press", pp0, 0);
        check("reset_release", rp0, 0);
        check("reset_fs_x", mx2, 320);

        // Basic move; one-cycle latency from push edge to pop edge
        push_one(8'd5, 8'hFD, 2'b00);
        check("move_not_yet_x", mx0, 320);
        step();
        check("move_x", mx0, 325);
        check("move_y", my0, 237);

        // Edge limits
        load(16'd635, 16'd2);
        push_one(8'd10, 8'h80, 2'b00);
        step();
        check("clamp_x", mx0, 639);
        check("clamp_y", my0, 0);
        check("wrap_big_x", mx1, 5);
        check("wrap_big_y", my1, 354);
        load(16'd635, 16'd2);
        push_one(8'd10, 8'hFD, 2'b00);
        step();
        check("clamp2_x", mx0, 639);
        check("clamp2_y", my0, 0);
        check("wrap_x", mx1, 5);
        check("wrap_y", my1, 479);
        load(16'd2000, 16'd900);
        check("set_sat_x", mx0, 639);
        check("set_sat_y", my0, 479);

        // Button sequence pushed back to back; each pop lands one edge after its push
        rpt_valid = 1'b1;
        rpt_dx    = '0;
        rpt_dy    = '0;
        for (int i = 0; i < 4; i++) begin
            rpt_buttons = btn_seq[i];
            step();
            if (i > 0) begin
                check($sformatf("press_%0d", i - 1), pp0, exp_press[i - 1]);
                check($sformatf("release_%0d", i - 1), rp0, exp_rel[i - 1]);
            end
        end
        rpt_valid = 1'b0;
        step();
        check("press_3", pp0, exp_press[3]);
        check("release_3", rp0, exp_rel[3]);
        check("btn_after_seq", pb0, 0);
        step();
        check("press_idle", pp0, 0);
        check("release_idle", rp0, 0);

        // Held set_valid blocks pops; FIFO fills after four accepts
        set_valid   = 1'b1;
        set_x       = '0;
        set_y       = '0;
        rpt_valid   = 1'b1;
        rpt_dx      = 8'd1;
        rpt_dy      = '0;
        rpt_buttons = '0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_ready_%0d", i), rdy0, (i < 4) ? 1 : 0);
            step();
        end
        check("hold_x", mx0, 0);
        set_valid = 1'b0;
        step();
        check("drain_x1", mx0, 1);
        check("drain_ready", rdy0, 1);
        step();
        rpt_valid = 1'b0;
        check("drain_x2", mx0, 2);
        step();
        check("drain_x3", mx0, 3);
        step();
        check("drain_x4", mx0, 4);
        step();
        check("fifth_x", mx0, 5);
        step();
        check("settled_x", mx0, 5);
        check("settled_y", my0, 0);
        check("settled_ready", rdy0, 1);

        // Frame-synchronous exports
        do_reset();
        push_one(8'd7, 8'd0, 2'b00);
        step();
        step();
        check("fs_hold_x", mx2, 320);
        check("direct_x", mx0, 327);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fs_update_x", mx2, 327);
        check("fs_update_y", my2, 240);
        push_one(8'd1, 8'd0, 2'b00);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fs_pre_update_x", mx2, 327);
        check("direct_x2", mx0, 328);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fs_late_x", mx2, 328);

        // Reset mid-stream discards queued reports
        set_valid = 1'b1;
        rpt_valid = 1'b1;
        rpt_dx    = 8'd3;
        repeat (3) step();
        rst_n = 1'b0;
        #2;
        rst_n     = 1'b1;
        set_valid = 1'b0;
        rpt_valid = 1'b0;
        step();
        step();
        check("flush_x", mx0, 320);
        check("flush_ready", rdy0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
